// File: rtl/gpioemu_pkg.sv
// ============================================================================
// Module      : gpioemu_pkg
// Description : Shared constants and FSM state type for the GPIO-emulator host.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpioemu_pkg;

    localparam logic [15:0] c_addr_a1     = 16'h037F;
    localparam logic [15:0] c_addr_a2     = 16'h0388;
    localparam logic [15:0] c_addr_start  = 16'h03A1;
    localparam logic [15:0] c_addr_result = 16'h0390;
    localparam logic [15:0] c_addr_ones   = 16'h0398;
    localparam logic [15:0] c_addr_status = 16'h03A0;

    localparam int c_stat_ready_bit = 1;
    localparam int c_stat_valid_bit = 0;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_WR_A1   = 4'd1,
        S_WR_A2   = 4'd2,
        S_WR_GO   = 4'd3,
        S_SETTLE  = 4'd4,
        S_RD_STAT = 4'd5,
        S_RD_W0   = 4'd6,
        S_RD_W1   = 4'd7,
        S_RD_ONES = 4'd8,
        S_RESP    = 4'd9
    } state_t;

endpackage

`default_nettype wire

// File: rtl/gpioemu_host_if.sv
// ============================================================================
// Module      : gpioemu_host_if
// Description : Job request/response ports and peripheral strobe bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gpioemu_host_if;
    import gpioemu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_a1;
    logic [23:0] req_a2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_w;
    logic [23:0] resp_ones;
    logic        resp_ovf;
    logic        resp_timeout;
    logic        resp_mismatch;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;

    // master: the host engine; slave: job source, consumer and peripheral
    modport master (
        input  req_valid, req_a1, req_a2, resp_ready, sdata_in,
        output req_ready, resp_valid, resp_w, resp_ones, resp_ovf,
               resp_timeout, resp_mismatch, saddress, srd, swr, sdata_out
    );

    modport slave (
        output req_valid, req_a1, req_a2, resp_ready, sdata_in,
        input  req_ready, resp_valid, resp_w, resp_ones, resp_ovf,
               resp_timeout, resp_mismatch, saddress, srd, swr, sdata_out
    );

endinterface

`default_nettype wire

// File: rtl/gpioemu_host_popcount32.sv
// ============================================================================
// Module      : popcount32
// Description : Combinational ones count of a 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount32 (
    input  logic [31:0] i_data,
    output logic [5:0]  o_count
);

    always_comb begin
        o_count = 6'd0;
        for (int i = 0; i < 32; i++) begin
            o_count = o_count + {5'd0, i_data[i]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/gpioemu_host.sv
// ============================================================================
// Module      : gpioemu_host
// Description : Runs a 24x24 multiply job on the GPIO-emulator peripheral.
//               GPIOEMU_HOST_POPCHK_EN adds a local popcount cross-check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpioemu_host
    import gpioemu_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int POLL_LIMIT    = 64
) (
    input  logic           clk,
    input  logic           reset,
    gpioemu_host_if.master bus
);

    localparam int c_hold_phase = STROBE_CYCLES + 1;
    localparam int c_settle_len = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES : 1;
    localparam int c_cnt_max    = (c_hold_phase > c_settle_len) ? c_hold_phase : c_settle_len;
    localparam int c_phw        = $clog2(c_cnt_max + 1);
    localparam int c_pollw      = $clog2(POLL_LIMIT + 1);

    localparam logic [c_phw-1:0]   c_hold        = c_phw'(c_hold_phase);
    localparam logic [c_phw-1:0]   c_strobe_last = c_phw'(STROBE_CYCLES);
    localparam logic [c_phw-1:0]   c_settle_last = c_phw'(c_settle_len - 1);
    localparam logic [c_pollw-1:0] c_poll_last   = c_pollw'(POLL_LIMIT - 1);

    state_t               r_state, w_state_nxt;
    logic [c_phw-1:0]     r_phase, w_phase_nxt;
    logic [c_pollw-1:0]   r_poll, w_poll_nxt;
    logic                 r_req_ready;
    logic [23:0]          r_a1, r_a2;
    logic [31:0]          r_resp_w;
    logic [23:0]          r_resp_ones;
    logic                 r_resp_ovf, r_resp_timeout, r_resp_mismatch;

    logic                 w_access, w_is_read, w_strobe, w_acc_done;
    logic                 w_accept, w_stat_ready, w_timeout, w_mismatch;
    logic [15:0]          w_addr;
    logic [31:0]          w_wdata;

    // Bus access decode; phase 0 = setup, 1..STROBE_CYCLES = strobe, last = hold
    always_comb begin
        w_access  = 1'b0;
        w_is_read = 1'b0;
        w_addr    = 16'h0000;
        w_wdata   = 32'h0000_0000;
        case (r_state)
            S_WR_A1:   begin w_access = 1'b1; w_addr = c_addr_a1; w_wdata = {8'h00, r_a1}; end
            S_WR_A2:   begin w_access = 1'b1; w_addr = c_addr_a2; w_wdata = {8'h00, r_a2}; end
            S_WR_GO:   begin w_access = 1'b1; w_addr = c_addr_start; end
            S_RD_STAT: begin w_access = 1'b1; w_is_read = 1'b1; w_addr = c_addr_status; end
            S_RD_W0,
            S_RD_W1:   begin w_access = 1'b1; w_is_read = 1'b1; w_addr = c_addr_result; end
            S_RD_ONES: begin w_access = 1'b1; w_is_read = 1'b1; w_addr = c_addr_ones; end
            default:   ;
        endcase
        w_strobe   = w_access && (r_phase != '0) && (r_phase <= c_strobe_last);
        w_acc_done = w_access && (r_phase == c_hold);
    end

    assign w_accept     = (r_state == S_IDLE) && r_req_ready && bus.req_valid;
    assign w_stat_ready = bus.sdata_in[c_stat_ready_bit];
    assign w_timeout    = (r_state == S_RD_STAT) && w_acc_done && !w_stat_ready
                          && (r_poll == c_poll_last);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_poll_nxt  = r_poll;
        if (w_access) begin
            w_phase_nxt = w_acc_done ? '0 : r_phase + 1'b1;
        end
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WR_A1;
                    w_phase_nxt = '0;
                    w_poll_nxt  = '0;
                end
            end
            S_WR_A1:   if (w_acc_done) w_state_nxt = S_WR_A2;
            S_WR_A2:   if (w_acc_done) w_state_nxt = S_WR_GO;
            S_WR_GO:   if (w_acc_done) w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (r_phase == c_settle_last) begin
                    w_state_nxt = S_RD_STAT;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end
            S_RD_STAT: begin
                if (w_acc_done) begin
                    if (w_stat_ready) begin
                        w_state_nxt = S_RD_W0;
                    end else if (r_poll == c_poll_last) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_poll_nxt = r_poll + 1'b1;
                    end
                end
            end
            S_RD_W0:   if (w_acc_done) w_state_nxt = S_RD_W1;
            S_RD_W1:   if (w_acc_done) w_state_nxt = S_RD_ONES;
            S_RD_ONES: if (w_acc_done) w_state_nxt = S_RESP;
            S_RESP:    if (bus.resp_ready) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_poll      <= '0;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_poll      <= w_poll_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
        end
    end

    // Read data is captured at the end of each access's hold cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a1            <= '0;
            r_a2            <= '0;
            r_resp_w        <= '0;
            r_resp_ones     <= '0;
            r_resp_ovf      <= 1'b0;
            r_resp_timeout  <= 1'b0;
            r_resp_mismatch <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a1           <= bus.req_a1;
                r_a2           <= bus.req_a2;
                r_resp_timeout <= 1'b0;
            end
            if (w_acc_done) begin
                case (r_state)
                    S_RD_STAT: begin
                        if (w_stat_ready) begin
                            r_resp_ovf <= ~bus.sdata_in[c_stat_valid_bit];
                        end else if (w_timeout) begin
                            r_resp_w        <= '0;
                            r_resp_ones     <= '0;
                            r_resp_ovf      <= 1'b0;
                            r_resp_timeout  <= 1'b1;
                            r_resp_mismatch <= 1'b0;
                        end
                    end
                    S_RD_W1:   r_resp_w <= bus.sdata_in;
                    S_RD_ONES: begin
                        r_resp_ones     <= bus.sdata_in[23:0];
                        r_resp_mismatch <= w_mismatch;
                    end
                    default:   ;
                endcase
            end
        end
    end

`ifdef GPIOEMU_HOST_POPCHK_EN
    logic [5:0] w_pop;

    popcount32 u_popcount (
        .i_data  (r_resp_w),
        .o_count (w_pop)
    );

    assign w_mismatch = ({18'h0, w_pop} != bus.sdata_in[23:0]);
`else
    assign w_mismatch = 1'b0;
`endif

    assign bus.req_ready     = r_req_ready;
    assign bus.resp_valid    = (r_state == S_RESP);
    assign bus.resp_w        = r_resp_w;
    assign bus.resp_ones     = r_resp_ones;
    assign bus.resp_ovf      = r_resp_ovf;
    assign bus.resp_timeout  = r_resp_timeout;
    assign bus.resp_mismatch = r_resp_mismatch;
    assign bus.saddress      = w_addr;
    assign bus.srd           = w_strobe && w_is_read;
    assign bus.swr           = w_strobe && !w_is_read;
    assign bus.sdata_out     = w_wdata;

endmodule

`default_nettype wire

// File: tb/tb_gpioemu_host.sv
// ============================================================================
// Module      : tb_gpioemu_host
// Description : Self-checking bench for gpioemu_host with a peripheral model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpioemu_host;
    import gpioemu_pkg::*;

    localparam int STROBE_CYCLES = 2;
    localparam int SETTLE_CYCLES = 4;
    localparam int POLL_LIMIT    = 64;
    localparam int c_acc         = STROBE_CYCLES + 2;
    localparam int c_best_lat    = 7 * c_acc + SETTLE_CYCLES + 1;
    localparam int c_tmo_lat     = 3 * c_acc + SETTLE_CYCLES + POLL_LIMIT * c_acc + 1;
`ifdef GPIOEMU_HOST_POPCHK_EN
    localparam bit c_mm_exp = 1'b1;
`else
    localparam bit c_mm_exp = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gpioemu_host_if bus ();

    gpioemu_host #(
        .STROBE_CYCLES (STROBE_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .POLL_LIMIT    (POLL_LIMIT)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Peripheral model: acts on the rising edge of each strobe
    logic [23:0] m_a1, m_a2;
    logic [47:0] m_prod;
    logic [31:0] m_out;
    int          m_polls_left;
    int          cfg_poll_delay;
    bit          cfg_never;
    logic [23:0] cfg_bias;
    logic [47:0] wr_log [$];
    int          rd_stat, rd_res, bus_err, strobe_len;
    logic        prev_rd, prev_wr;

    always @(negedge clk) begin
        if (reset) begin
            strobe_len   = 0;
            prev_rd      = 1'b0;
            prev_wr      = 1'b0;
            bus.sdata_in = 32'h0;
        end else begin
            if (bus.srd && bus.swr) bus_err++;
            if (bus.srd || bus.swr) begin
                strobe_len++;
            end else if (strobe_len != 0) begin
                if (strobe_len != STROBE_CYCLES) bus_err++;
                strobe_len = 0;
            end
            if (bus.swr && !prev_wr) begin
                wr_log.push_back({bus.saddress, bus.sdata_out});
                case (bus.saddress)
                    c_addr_a1:    m_a1 = bus.sdata_out[23:0];
                    c_addr_a2:    m_a2 = bus.sdata_out[23:0];
                    c_addr_start: begin
                        m_prod       = 48'(m_a1) * 48'(m_a2);
                        m_out        = ~m_prod[31:0];
                        m_polls_left = cfg_poll_delay;
                    end
                    default:      bus_err++;
                endcase
            end
            if (bus.srd && !prev_rd) begin
                case (bus.saddress)
                    c_addr_status: begin
                        rd_stat++;
                        if (cfg_never || m_polls_left > 0) begin
                            bus.sdata_in = 32'h1;
                            if (m_polls_left > 0) m_polls_left--;
                        end else begin
                            bus.sdata_in = {30'h0, 1'b1, (m_prod[47:32] == 16'h0)};
                        end
                    end
                    c_addr_result: begin
                        rd_res++;
                        bus.sdata_in = m_out;
                        m_out        = m_prod[31:0];
                    end
                    c_addr_ones:   bus.sdata_in = 32'($countones(m_prod[31:0])) + {8'h0, cfg_bias};
                    default:       bus_err++;
                endcase
            end
            prev_rd = bus.srd;
            prev_wr = bus.swr;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] got_w;
    logic [23:0] got_ones;
    logic        got_ovf, got_to, got_mm;
    int          got_lat;

    task automatic run_job(input logic [23:0] a1, input logic [23:0] a2, input int pdelay,
                           input bit never, input logic [23:0] bias, input int rdelay);
        int          n;
        int          t0;
        logic [58:0] snap;
        cfg_poll_delay = pdelay;
        cfg_never      = never;
        cfg_bias       = bias;
        wr_log.delete();
        rd_stat = 0;
        rd_res  = 0;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_a1    = a1;
        bus.req_a2    = a2;
        t0            = cyc;
        @(negedge clk);
        n = 0;
        // req_valid stays high with junk operands: must be ignored while busy
        while (bus.resp_valid !== 1'b1 && n < 400) begin
            bus.req_a1 = 24'($urandom);
            bus.req_a2 = 24'($urandom);
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b0;
        got_lat  = (bus.resp_valid === 1'b1) ? cyc - t0 : -1;
        got_w    = bus.resp_w;
        got_ones = bus.resp_ones;
        got_ovf  = bus.resp_ovf;
        got_to   = bus.resp_timeout;
        got_mm   = bus.resp_mismatch;
        snap     = {got_w, got_ones, got_ovf, got_to, got_mm};
        for (int i = 0; i < rdelay; i++) begin
            @(negedge clk);
            check("hold_fields", {bus.resp_valid, bus.resp_w, bus.resp_ones, bus.resp_ovf,
                                  bus.resp_timeout, bus.resp_mismatch}, {1'b1, snap});
            check("hold_quiet", {bus.req_ready, bus.srd, bus.swr}, 3'b000);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("resp_release", {bus.resp_valid, bus.req_ready}, 2'b01);
    endtask

    task automatic check_job(input string tag, input logic [31:0] w, input logic [23:0] ones,
                             input bit ovf, input bit to, input bit mm, input int lat);
        check({tag, "_w"}, got_w, w);
        check({tag, "_ones"}, got_ones, ones);
        check({tag, "_flags"}, {got_ovf, got_to, got_mm}, {ovf, to, mm});
        check({tag, "_latency"}, 64'(got_lat), 64'(lat));
    endtask

    task automatic check_writes(input logic [23:0] a1, input logic [23:0] a2);
        logic [47:0] exp [3];
        exp[0] = {c_addr_a1, 8'h00, a1};
        exp[1] = {c_addr_a2, 8'h00, a2};
        exp[2] = {c_addr_start, 32'h0};
        check("wr_count", wr_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("wr_seq", (i < wr_log.size()) ? wr_log[i] : 48'hx, exp[i]);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        logic quiet;
        bus.req_valid  = 1'b0;
        bus.req_a1     = '0;
        bus.req_a2     = '0;
        bus.resp_ready = 1'b0;
        reset          = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_ctrl", {bus.req_ready, bus.resp_valid, bus.srd, bus.swr,
                           bus.resp_ovf, bus.resp_timeout, bus.resp_mismatch}, 7'b0);
        check("rst_bus", {bus.saddress, bus.sdata_out}, 48'h0);
        check("rst_resp", {bus.resp_w, bus.resp_ones}, 56'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_ready", bus.req_ready, 1'b1);

        run_job(24'd3, 24'd5, 0, 1'b0, 24'd0, 0);
        check_writes(24'd3, 24'd5);
        check_job("j3x5", 32'd15, 24'd4, 1'b0, 1'b0, 1'b0, c_best_lat);

        run_job(24'hFFFFFF, 24'hFFFFFF, 0, 1'b0, 24'd0, 0);
        check_job("jmax", 32'hFE000001, 24'd8, 1'b1, 1'b0, 1'b0, c_best_lat);

        run_job(24'h000123, 24'h000456, 0, 1'b1, 24'd0, 0);
        check_job("jtmo", 32'd0, 24'd0, 1'b0, 1'b1, 1'b0, c_tmo_lat);
        check("tmo_polls", rd_stat, POLL_LIMIT);
        check("tmo_result_reads", rd_res, 0);

        // Reset while a status read strobe is high
        cfg_never = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_a1    = 24'd7;
        bus.req_a2    = 24'd9;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!(bus.srd === 1'b1 && bus.saddress === c_addr_status) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_found", bus.srd, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_strobes", {bus.srd, bus.swr}, 2'b00);
        check("rst_mid_ready_low", bus.req_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", bus.req_ready, 1'b1);
        quiet = 1'b0;
        repeat (8) begin
            @(negedge clk);
            quiet = quiet | bus.srd | bus.swr | bus.resp_valid;
        end
        check("rst_mid_quiet", quiet, 1'b0);

        run_job(24'd1000, 24'd2001, 0, 1'b0, 24'd0, 10);
        check_job("jhold", 32'd2001000, 24'($countones(32'd2001000)), 1'b0, 1'b0, 1'b0, c_best_lat);

        run_job(24'd3, 24'd5, 0, 1'b0, 24'd1, 0);
        check_job("jmm", 32'd15, 24'd5, 1'b0, 1'b0, c_mm_exp, c_best_lat);

        for (int j = 0; j < 8; j++) begin
            logic [23:0] a1, a2;
            logic [47:0] p;
            int          pd, rd;
            a1 = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 4095));
            a2 = ($urandom_range(0, 1) == 1) ? 24'($urandom) : 24'($urandom_range(0, 4095));
            pd = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            p  = 48'(a1) * 48'(a2);
            run_job(a1, a2, pd, 1'b0, 24'd0, rd);
            check_writes(a1, a2);
            check_job("jrnd", p[31:0], 24'($countones(p[31:0])), (p[47:32] != 16'h0),
                      1'b0, 1'b0, c_best_lat + pd * c_acc);
            check("rnd_polls", rd_stat, pd + 1);
            check("rnd_result_reads", rd_res, 2);
        end

        check("bus_protocol", bus_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
